// File: rtl/avl_pio_bank.sv
// Multi-channel Avalon-MM PIO bank: per-channel output register, synchronised
// input with edge capture and interrupt mask, and one combined level interrupt.
module avl_pio_bank #(
    parameter int NCH         = 4,
    parameter int DW          = 16,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 0,
    parameter int AW          = $clog2(NCH) + 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AW-1:0]     avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic [3:0]        avs_byteenable,
    output logic [31:0]       avs_readdata,
    output logic              avs_readdatavalid,
    output logic [1:0]        avs_response,
    output logic              avs_waitrequest,
    input  logic [NCH*DW-1:0] pio_in,
    output logic [NCH*DW-1:0] pio_out,
    output logic              irq
);

    localparam int PINW = NCH * DW;
    localparam int PW   = $clog2(SYNC_STAGES + 2);
    localparam logic [PW-1:0] PRIME_DONE = PW'(SYNC_STAGES + 1);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] REG_OUT  = 2'd0;
    localparam logic [1:0] REG_IN   = 2'd1;
    localparam logic [1:0] REG_EDGE = 2'd2;
    localparam logic [1:0] REG_MASK = 2'd3;

    function automatic logic [PINW-1:0] detect_edge(input logic [PINW-1:0] cur,
                                                    input logic [PINW-1:0] prev);
        case (EDGE_MODE)
            0:       return cur & ~prev;
            1:       return ~cur & prev;
            default: return cur ^ prev;
        endcase
    endfunction

    logic [1:0]      reg_sel;
    logic [31:0]     chan_ext;
    logic            chan_ok;
    logic            wr_acc;
    logic            rd_acc;
    logic [31:0]     be_mask;
    logic [31:0]     wd_m;
    logic [DW-1:0]   wr_bits;
    logic [DW-1:0]   wr_keep;
    logic            unused_wd;
    logic [NCH-1:0]  wsel;

    logic [PINW-1:0] sync_p [SYNC_STAGES];
    logic [PINW-1:0] hist_p;
    logic [PINW-1:0] sync_out;
    logic [PINW-1:0] cap;
    logic [PW-1:0]   prime_cnt;
    logic            prime_done;

    logic [DW-1:0]   out_q  [NCH];
    logic [DW-1:0]   edge_q [NCH];
    logic [DW-1:0]   mask_q [NCH];
    logic [31:0]     rd_word;
    logic            irq_any;

    assign reg_sel  = avs_address[1:0];
    assign chan_ext = 32'(avs_address) >> 2;
    assign chan_ok  = chan_ext < 32'(NCH);

    // A simultaneous read is dropped in favour of the write.
    assign wr_acc = avs_write;
    assign rd_acc = avs_read & ~avs_write;

    assign be_mask = {{8{avs_byteenable[3]}}, {8{avs_byteenable[2]}},
                      {8{avs_byteenable[1]}}, {8{avs_byteenable[0]}}};
    assign wd_m      = avs_writedata & be_mask;
    assign wr_bits   = wd_m[DW-1:0];
    assign wr_keep   = ~be_mask[DW-1:0];
    assign unused_wd = ^wd_m;

    assign avs_waitrequest = 1'b0;

    always_comb begin
        wsel = '0;
        for (int c = 0; c < NCH; c++) begin
            wsel[c] = wr_acc && (chan_ext == 32'(c));
        end
    end

    // Input synchroniser and edge-history stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_p[s] <= '0;
            end
            hist_p    <= '0;
            prime_cnt <= '0;
        end else begin
            sync_p[0] <= pio_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_p[s] <= sync_p[s-1];
            end
            hist_p <= sync_out;
            if (prime_cnt != PRIME_DONE) begin
                prime_cnt <= prime_cnt + 1'b1;
            end
        end
    end

    assign sync_out   = sync_p[SYNC_STAGES-1];
    assign prime_done = (prime_cnt == PRIME_DONE);
    assign cap        = prime_done ? detect_edge(sync_out, hist_p) : '0;

    // Register file; a capture on the same bit overrides a write-1-to-clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NCH; c++) begin
                out_q[c]  <= '0;
                edge_q[c] <= '0;
                mask_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (wsel[c] && reg_sel == REG_OUT) begin
                    out_q[c] <= (out_q[c] & wr_keep) | wr_bits;
                end
                if (wsel[c] && reg_sel == REG_MASK) begin
                    mask_q[c] <= (mask_q[c] & wr_keep) | wr_bits;
                end
                edge_q[c] <= (edge_q[c] & ~({DW{wsel[c] && reg_sel == REG_EDGE}} & wr_bits))
                             | cap[c*DW +: DW];
            end
        end
    end

    always_comb begin
        rd_word = '0;
        for (int c = 0; c < NCH; c++) begin
            if (chan_ext == 32'(c)) begin
                case (reg_sel)
                    REG_OUT:  rd_word = 32'(out_q[c]);
                    REG_IN:   rd_word = 32'(sync_out[c*DW +: DW]);
                    REG_EDGE: rd_word = 32'(edge_q[c]);
                    default:  rd_word = 32'(mask_q[c]);
                endcase
            end
        end
    end

    // Response stage, one cycle behind the accepted request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            avs_readdatavalid <= 1'b0;
            avs_readdata      <= '0;
            avs_response      <= RESP_OKAY;
        end else begin
            avs_readdatavalid <= rd_acc;
            avs_readdata      <= rd_acc ? rd_word : '0;
            if ((rd_acc || wr_acc) && !chan_ok) begin
                avs_response <= RESP_SLVERR;
            end else begin
                avs_response <= RESP_OKAY;
            end
        end
    end

    always_comb begin
        irq_any = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            irq_any = irq_any | (|(edge_q[c] & mask_q[c]));
        end
    end

    assign irq = irq_any;

    for (genvar c = 0; c < NCH; c++) begin : g_out
        assign pio_out[c*DW +: DW] = out_q[c];
    end

endmodule

// File: tb/tb_avl_pio_bank.sv
// Scoreboard bench for avl_pio_bank: instance A (4 channels, rising edges) and
// instance B (3 channels, both edges) on a shared clock and reset.
module tb_avl_pio_bank;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]  a_addr = '0, b_addr = '0;
    logic        a_rd = 1'b0, b_rd = 1'b0, a_wr = 1'b0, b_wr = 1'b0;
    logic [31:0] a_wdata = '0, b_wdata = '0;
    logic [3:0]  a_be = '0, b_be = '0;
    logic [31:0] a_rdata, b_rdata;
    logic        a_rvalid, b_rvalid, a_wreq, b_wreq, irq_a, irq_b;
    logic [1:0]  a_resp, b_resp;
    logic [63:0] pin_a = '0, pout_a;
    logic [47:0] pin_b = '0, pout_b;

    avl_pio_bank #(.NCH(4), .DW(16), .SYNC_STAGES(2), .EDGE_MODE(0)) dut_a (
        .clk(clk), .reset(reset),
        .avs_address(a_addr), .avs_read(a_rd), .avs_write(a_wr),
        .avs_writedata(a_wdata), .avs_byteenable(a_be),
        .avs_readdata(a_rdata), .avs_readdatavalid(a_rvalid),
        .avs_response(a_resp), .avs_waitrequest(a_wreq),
        .pio_in(pin_a), .pio_out(pout_a), .irq(irq_a)
    );

    avl_pio_bank #(.NCH(3), .DW(16), .SYNC_STAGES(2), .EDGE_MODE(2)) dut_b (
        .clk(clk), .reset(reset),
        .avs_address(b_addr), .avs_read(b_rd), .avs_write(b_wr),
        .avs_writedata(b_wdata), .avs_byteenable(b_be),
        .avs_readdata(b_rdata), .avs_readdatavalid(b_rvalid),
        .avs_response(b_resp), .avs_waitrequest(b_wreq),
        .pio_in(pin_b), .pio_out(pout_b), .irq(irq_b)
    );

    int nvec = 0;
    int nfail = 0;
    int a_run = 0;
    int b_run = 0;
    logic [37:0] qa [$];
    logic [37:0] qb [$];

    localparam logic [3:0]  TA [8] = '{4'd8, 4'd12, 4'd7, 4'd5, 4'd6, 4'd0, 4'd1, 4'd14};
    localparam logic [31:0] TD [8] = '{32'h0000_BE11, 32'h0000_CAFE, 32'h0000_0020, 32'h0000_0020,
                                       32'h0, 32'h0, 32'h0, 32'h0};

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic rd_req(input int d, input logic [3:0] a, input logic [31:0] ed,
                          input logic [1:0] er);
        if (d == 0) begin
            a_addr = a; a_rd = 1'b1; qa.push_back({a, er, ed});
        end else begin
            b_addr = a; b_rd = 1'b1; qb.push_back({a, er, ed});
        end
        tick(1);
        a_rd = 1'b0; b_rd = 1'b0;
    endtask

    task automatic wr_req(input int d, input logic [3:0] a, input logic [31:0] wd,
                          input logic [3:0] be);
        if (d == 0) begin
            a_addr = a; a_wdata = wd; a_be = be; a_wr = 1'b1;
        end else begin
            b_addr = a; b_wdata = wd; b_be = be; b_wr = 1'b1;
        end
        tick(1);
        a_wr = 1'b0; b_wr = 1'b0;
    endtask

    task automatic monitor();
        logic [37:0] e;
        forever begin
            @(negedge clk);
            if (a_rvalid) begin
                nvec++;
                if (qa.size() == 0) begin
                    nfail++;
                    $display("FAIL a_rdv_unexpected: got data %h, expected no response", a_rdata);
                end else begin
                    e = qa.pop_front();
                    if ({a_resp, a_rdata} !== e[33:0]) begin
                        nfail++;
                        $display("FAIL a_read@%0d: got resp=%b data=%h expected resp=%b data=%h",
                                 e[37:34], a_resp, a_rdata, e[33:32], e[31:0]);
                    end
                end
                a_run++;
            end else begin
                a_run = 0;
            end
            if (b_rvalid) begin
                nvec++;
                if (qb.size() == 0) begin
                    nfail++;
                    $display("FAIL b_rdv_unexpected: got data %h, expected no response", b_rdata);
                end else begin
                    e = qb.pop_front();
                    if ({b_resp, b_rdata} !== e[33:0]) begin
                        nfail++;
                        $display("FAIL b_read@%0d: got resp=%b data=%h expected resp=%b data=%h",
                                 e[37:34], b_resp, b_rdata, e[33:32], e[31:0]);
                    end
                end
                b_run++;
            end else begin
                b_run = 0;
            end
        end
    endtask

    initial begin
        fork
            monitor();
        join_none

        // reset values
        tick(2);
        chk("rst_pout_a", pout_a, 64'h0);
        chk("rst_rvalid_a", a_rvalid, 0);
        chk("rst_rdata_a", a_rdata, 0);
        chk("rst_resp_a", a_resp, 0);
        chk("rst_irq_a", irq_a, 0);
        chk("waitreq_a", a_wreq, 0);
        reset = 1'b0;
        tick(2);

        // mid-run reset with a read response pending and inputs high
        wr_req(0, 4'd0, 32'h0000_1234, 4'hF);
        wr_req(0, 4'd3, 32'h0000_FFFF, 4'hF);
        chk("pre_rst_pout_a", pout_a, 64'h1234);
        a_addr = 4'd0; a_rd = 1'b1;
        tick(1);
        a_rd = 1'b0;
        reset = 1'b1;
        pin_a = '1;
        #1;
        chk("rst_drops_rdv", a_rvalid, 0);
        tick(2);
        chk("rst2_pout_a", pout_a, 64'h0);
        chk("rst2_irq_a", irq_a, 0);
        reset = 1'b0;
        tick(6);
        chk("prime_irq_a", irq_a, 0);
        for (int r = 0; r < 16; r++) begin
            rd_req(0, 4'(r), (r % 4 == 1) ? 32'h0000_FFFF : 32'h0, 2'b00);
        end
        @(negedge clk); #1;
        chk("b2b16_run", a_run, 16);

        // falling edges are ignored in rising mode
        pin_a = '0;
        tick(4);
        rd_req(0, 4'd6, 32'h0, 2'b00);
        rd_req(0, 4'd2, 32'h0, 2'b00);

        // OUT with byte enables
        wr_req(0, 4'd8, 32'hDEAD_BEEF, 4'b0011);
        chk("be0011_pout", pout_a, 64'h0000_BEEF_0000_0000);
        chk("wr_resp_ok", a_resp, 2'b00);
        chk("wr_no_rdv", a_rvalid, 0);
        rd_req(0, 4'd8, 32'h0000_BEEF, 2'b00);
        wr_req(0, 4'd8, 32'h1234_5678, 4'b1100);
        rd_req(0, 4'd8, 32'h0000_BEEF, 2'b00);
        wr_req(0, 4'd8, 32'h0000_0011, 4'b0001);
        chk("be0001_pout", pout_a, 64'h0000_BE11_0000_0000);

        // rising edge on ch1 bit 5: IN after +1 edge, EDGE after +2
        pin_a[21] = 1'b1;
        tick(1);
        rd_req(0, 4'd5, 32'h0, 2'b00);
        rd_req(0, 4'd6, 32'h0, 2'b00);
        rd_req(0, 4'd6, 32'h0000_0020, 2'b00);
        rd_req(0, 4'd5, 32'h0000_0020, 2'b00);
        chk("edge_unmasked_irq", irq_a, 0);
        wr_req(0, 4'd7, 32'h0000_0020, 4'hF);
        chk("mask_irq_on", irq_a, 1);
        wr_req(0, 4'd6, 32'h0000_0020, 4'hF);
        chk("w1c_irq_off", irq_a, 0);
        rd_req(0, 4'd6, 32'h0, 2'b00);

        // W1C in the same cycle as a new capture
        pin_a[21] = 1'b0;
        tick(4);
        pin_a[21] = 1'b1;
        tick(2);
        wr_req(0, 4'd6, 32'h0000_0020, 4'hF);
        chk("w1c_vs_cap_irq", irq_a, 1);
        rd_req(0, 4'd6, 32'h0000_0020, 2'b00);
        wr_req(0, 4'd6, 32'h0000_0020, 4'hF);
        chk("w1c2_irq", irq_a, 0);

        // IN is read-only
        wr_req(0, 4'd5, 32'h0000_FFFF, 4'hF);
        chk("in_wr_resp", a_resp, 2'b00);
        rd_req(0, 4'd5, 32'h0000_0020, 2'b00);

        // both-edge mode on instance B
        wr_req(1, 4'd7, 32'h0000_0020, 4'hF);
        pin_b[21] = 1'b1;
        tick(3);
        chk("b_rise_irq", irq_b, 1);
        wr_req(1, 4'd6, 32'h0000_0020, 4'hF);
        chk("b_w1c_irq", irq_b, 0);
        pin_b[21] = 1'b0;
        tick(2);
        wr_req(1, 4'd6, 32'h0000_0020, 4'hF);
        chk("b_fall_vs_w1c_irq", irq_b, 1);
        rd_req(1, 4'd6, 32'h0000_0020, 2'b00);
        wr_req(1, 4'd6, 32'h0000_0020, 4'hF);
        chk("b_w1c2_irq", irq_b, 0);

        // out-of-range channel on the 3-channel instance
        wr_req(1, 4'd0, 32'h0000_5A5A, 4'hF);
        chk("b_inrange_resp", b_resp, 2'b00);
        wr_req(1, 4'd13, 32'hFFFF_FFFF, 4'hF);
        chk("b_oor_wr_resp", b_resp, 2'b10);
        chk("b_oor_wr_rdv", b_rvalid, 0);
        chk("b_oor_pout", pout_b, 48'h0000_0000_5A5A);
        tick(1);
        chk("b_resp_one_cycle", b_resp, 2'b00);
        wr_req(1, 4'd15, 32'h0000_FFFF, 4'hF);
        chk("b_oor_wr15_resp", b_resp, 2'b10);
        rd_req(1, 4'd12, 32'h0, 2'b10);
        rd_req(1, 4'd13, 32'h0, 2'b10);
        rd_req(1, 4'd3, 32'h0, 2'b00);
        rd_req(1, 4'd0, 32'h0000_5A5A, 2'b00);

        // throughput: 8 back-to-back reads
        wr_req(0, 4'd12, 32'h0000_CAFE, 4'hF);
        tick(1);
        for (int i = 0; i < 8; i++) begin
            rd_req(0, TA[i], TD[i], 2'b00);
        end
        @(negedge clk); #1;
        chk("b2b8_run", a_run, 8);

        // read and write together: write wins, no response
        tick(1);
        a_addr = 4'd0; a_wdata = 32'h0000_7777; a_be = 4'hF; a_rd = 1'b1; a_wr = 1'b1;
        tick(1);
        a_rd = 1'b0; a_wr = 1'b0;
        chk("rw_no_rdv", a_rvalid, 0);
        chk("rw_pout", pout_a, 64'hCAFE_BE11_0000_7777);
        rd_req(0, 4'd0, 32'h0000_7777, 2'b00);

        tick(3);
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/avl_pio_bank.md
# avl_pio_bank

Parametrised multi-channel Avalon-MM PIO peripheral that replaces the fixed-width LED, switch and HEX PIO instances in the SoC with one block. It provides N channels of configurable width, each with an output register, a synchronised input with per-bit edge capture and an interrupt mask, and a combined interrupt. It sits on the dmem-side Avalon-MM interconnect as a slave with fixed read latency 1.

## Interface
- NCH, 4: number of channels, 1..8
- DW, 16: bits per channel, 1..32; register bits above DW read 0
- SYNC_STAGES, 2: input synchroniser depth, 2..4
- EDGE_MODE, 0: capture edge; 0 rising, 1 falling, 2 both
- AW, clog2(NCH)+2: word address width
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- avs_address  in  AW  word address {channel, reg}
- avs_read  in  1  read request
- avs_write  in  1  write request
- avs_writedata  in  32  write data
- avs_byteenable  in  4  byte lanes for writes
- avs_readdata  out  32  read data, valid with avs_readdatavalid
- avs_readdatavalid  out  1  read response strobe
- avs_response  out  2  00 OKAY, 10 SLVERR
- avs_waitrequest  out  1  tied 0; every request accepted in its cycle
- pio_in  in  NCH*DW  asynchronous inputs, channel c at [c*DW +: DW]
- pio_out  out  NCH*DW  output registers, same packing
- irq  out  1  interrupt, level, active-high

## Operation
- Register map per channel c (word address c*4 + r):
  - r=0 OUT: RW; drives pio_out channel c
  - r=1 IN: RO; synchroniser output; writes ignored, OKAY
  - r=2 EDGE: write-1-to-clear capture bits
  - r=3 MASK: RW interrupt enable per bit
- Writes honour avs_byteenable per byte; bits at or above DW are never stored.
- Channel index >= NCH: reads return 0 with SLVERR, writes ignored with SLVERR (on the next-cycle response, see Timing).
- Synchroniser: SYNC_STAGES flops per bit, plus one history flop for edge detection.
- Edge detect per bit compares synchroniser output with the history flop, per EDGE_MODE, and sets the EDGE bit.
- Priming counter: after reset, edge detection is disabled for SYNC_STAGES+1 cycles. Inputs held high at reset must not produce a capture.
- irq = OR over all channels of (EDGE & MASK); combinational from registers, no extra delay.
- Simultaneous W1C and a new edge on the same bit: capture wins, bit stays 1.
- avs_read and avs_write in the same cycle: write performed, read ignored, no readdatavalid.
- Reset values: pio_out 0, all OUT/EDGE/MASK 0, synchroniser and history 0, avs_readdatavalid 0, avs_readdata 0, avs_response 00, irq 0, priming counter 0.
- Reset mid-transaction: a pending readdatavalid is dropped and no response is issued.

## Timing
- Read accepted at edge k: avs_readdatavalid, avs_readdata and avs_response are registered and valid for exactly one cycle after edge k+1.
- Back-to-back reads give back-to-back valid responses in order, with no bubbles.
- Write response: avs_response carries SLVERR for the cycle after an out-of-range write. No readdatavalid accompanies a write.
- OUT write at edge k: pio_out changes after edge k; a read in cycle k+1 returns the new value.
- pio_in change sampled at edge k:
  - IN reflects it after edge k+SYNC_STAGES-1.
  - The EDGE bit and irq assert after edge k+SYNC_STAGES.
- W1C at edge k: the EDGE bit clears after edge k; irq deasserts in the same cycle if no other enabled bit is set.
- The MASK write takes effect on irq in the cycle after the write edge.

## Test plan
- Reset and readback: assert reset mid-run with pio_in all ones, release -> all registers read 0, readdatavalid exactly 1 cycle after each read, no EDGE bits set after priming (defaults: NCH=4, DW=16).
- OUT with byte enables:
  - Write 0xDEADBEEF, be=0011, to ch2 OUT -> pio_out[47:32]=0xBEEF, readback 0x0000BEEF.
  - Write be=1100 -> value unchanged (bits >= DW).
- Edge capture, EDGE_MODE=0:
  - Raise pio_in bit 5 of ch1 -> ch1 EDGE=0x0020 after SYNC_STAGES+1 edges, irq stays 0.
  - Set MASK=0x0020 -> irq=1.
  - W1C 0x0020 -> irq=0 next cycle.
- Simultaneous W1C and new edge on the same bit -> EDGE bit remains 1, irq remains 1. Repeat with EDGE_MODE=2, toggling the bit twice -> the bit is set on both transitions.
- Out-of-range: NCH=3, read address 12 -> readdata 0, response 10. Write address 13 -> no state change, response 10.
- Throughput: 8 back-to-back reads across all registers -> 8 consecutive readdatavalid pulses with correct data; read+write same cycle -> write applied, no readdatavalid.
